uart_tx: RTL and testbench

Buffered 8N1 UART transmitter that drains the one-cycle byte-write strobe produced by the CPU subsystem's UART TX MMIO register and serialises each byte onto a single TX line. It sits between the CPU/memory subsystem and the board TX pin. It absorbs bursts of console writes in a small FIFO, because the MMIO write path has no backpressure. Bytes that arrive while the FIFO is full are dropped and flagged.

---
 rtl/uart_tx_if.sv | 37 +++
 rtl/uart_tx.sv | 169 ++++++++++++++++
 tb/tb_uart_tx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte-write strobe and line/status signals of the buffered UART transmitter
//
// Ports (master = byte producer / observer, slave = uart_tx):
//   i_wr_en       one-cycle strobe, push i_wr_data
//   i_wr_data     byte to transmit
//   o_tx          serial line, idle high
//   o_busy        frame in progress or FIFO non-empty
//   o_fifo_count  FIFO occupancy
//   o_overflow    one-cycle pulse when a write is dropped
interface uart_tx_if #(
    parameter int FIFO_DEPTH = 16
);
    logic                          i_wr_en;
    logic [7:0]                    i_wr_data;
    logic                          o_tx;
    logic                          o_busy;
    logic [$clog2(FIFO_DEPTH):0]   o_fifo_count;
    logic                          o_overflow;

    modport master (
        output i_wr_en,
        output i_wr_data,
        input  o_tx,
        input  o_busy,
        input  o_fifo_count,
        input  o_overflow
    );

    modport slave (
        input  i_wr_en,
        input  i_wr_data,
        output o_tx,
        output o_busy,
        output o_fifo_count,
        output o_overflow
    );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered 8N1 UART transmitter with drop-on-full byte FIFO
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      uart_tx_if.slave: i_wr_en/i_wr_data in; o_tx, o_busy,
//            o_fifo_count, o_overflow out
module uart_tx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    uart_tx_if.slave  bus
);
    localparam int ClksPerBit = CLK_FREQ_HZ / BAUD_RATE;
    localparam int BaudW      = (ClksPerBit < 2) ? 1 : $clog2(ClksPerBit);
    localparam int PtrW       = $clog2(FIFO_DEPTH);
    localparam int CntW       = PtrW + 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
    localparam logic [CntW-1:0]  Depth    = CntW'(FIFO_DEPTH);

    generate
        if (ClksPerBit < 2) begin : g_bad_divisor
            $error("uart_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx: FIFO_DEPTH must be a power of two, at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_q, bit_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic              tx_q, tx_d;
    logic              ovf_q;
    logic              pop;
    logic              push;
    logic              drop;
    logic              full;
    logic              empty;
    logic              last;

    assign full  = (count_q == Depth);
    assign empty = (count_q == '0);
    assign last  = (baud_q == BaudLast);
    // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign push  = bus.i_wr_en && (!full || pop);
    assign drop  = bus.i_wr_en && full && !pop;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            ovf_q <= drop;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            DATA: begin
                if (last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            STOP: begin
                if (last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more bytes wait.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // The line level is derived from the next state so o_tx is a plain flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign bus.o_tx         = tx_q;
    assign bus.o_busy       = (state_q != IDLE) || (count_q != '0);
    assign bus.o_fifo_count = count_q;
    assign bus.o_overflow   = ovf_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx against a frame-timeline model
module tb_uart_tx;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    uart_tx_if #(.FIFO_DEPTH(DEPTH)) ifa ();
    uart_tx_if #(.FIFO_DEPTH(DEPTH)) ifb ();

    uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(DEPTH)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifa)
    );

    uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(115_200), .FIFO_DEPTH(DEPTH)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int edge_n;
    int cpb [2];
    int wr_e [2][512];
    int st_e [2][512];
    logic [7:0] byt [2][512];
    int nf [2];
    int ovf_e [2];

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            nf[i]    = 0;
            ovf_e[i] = -1;
        end
    endtask

    // A byte written at edge k is kept if fewer than DEPTH bytes are still
    // waiting to start after edge k; its frame starts at k+1 or when the
    // previous frame ends, whichever is later.
    task automatic model_push(input int i, input logic [7:0] d, input int k);
        int live;
        int s;
        live = 0;
        for (int j = 0; j < nf[i]; j++) begin
            if (st_e[i][j] > k) live++;
        end
        if (live >= DEPTH) begin
            ovf_e[i] = k;
        end else begin
            s = k + 1;
            if (nf[i] > 0 && st_e[i][nf[i]-1] + 10 * cpb[i] > s) s = st_e[i][nf[i]-1] + 10 * cpb[i];
            wr_e[i][nf[i]] = k;
            st_e[i][nf[i]] = s;
            byt[i][nf[i]]  = d;
            nf[i]++;
        end
    endtask

    function automatic int occ(input int i, input int e);
        int c;
        c = 0;
        for (int j = 0; j < nf[i]; j++) begin
            if (wr_e[i][j] <= e && st_e[i][j] > e) c++;
        end
        return c;
    endfunction

    function automatic int frame_at(input int i, input int e);
        for (int j = 0; j < nf[i]; j++) begin
            if (e >= st_e[i][j] && e < st_e[i][j] + 10 * cpb[i]) return j;
        end
        return -1;
    endfunction

    function automatic logic exp_tx(input int i, input int e);
        int j;
        int b;
        logic [7:0] v;
        j = frame_at(i, e);
        if (j < 0) return 1'b1;
        b = (e - st_e[i][j]) / cpb[i];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        v = byt[i][j];
        return v[b-1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s edge=%0d obs=%0h exp=%0h", tag, edge_n, obs, expv);
        end
    endtask

    task automatic check_all();
        logic [31:0] o_tx;
        logic [31:0] o_cnt;
        logic [31:0] o_ovf;
        logic [31:0] o_busy;
        for (int i = 0; i < 2; i++) begin
            o_tx   = (i == 0) ? 32'(ifa.o_tx)         : 32'(ifb.o_tx);
            o_cnt  = (i == 0) ? 32'(ifa.o_fifo_count) : 32'(ifb.o_fifo_count);
            o_ovf  = (i == 0) ? 32'(ifa.o_overflow)   : 32'(ifb.o_overflow);
            o_busy = (i == 0) ? 32'(ifa.o_busy)       : 32'(ifb.o_busy);
            chk($sformatf("tx%0d", i),    o_tx,   32'(exp_tx(i, edge_n)));
            chk($sformatf("count%0d", i), o_cnt,  32'(occ(i, edge_n)));
            chk($sformatf("ovf%0d", i),   o_ovf,  32'(ovf_e[i] == edge_n));
            chk($sformatf("busy%0d", i),  o_busy, 32'(occ(i, edge_n) > 0 || frame_at(i, edge_n) >= 0));
        end
    endtask

    task automatic step(input logic we, input logic [7:0] d);
        ifa.i_wr_en   = we;
        ifa.i_wr_data = d;
        ifb.i_wr_en   = we;
        ifb.i_wr_data = d;
        @(posedge clk);
        edge_n++;
        if (we && rst_n) begin
            model_push(0, d, edge_n);
            model_push(1, d, edge_n);
        end
        #1;
        check_all();
        ifa.i_wr_en = 1'b0;
        ifb.i_wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(1'b0, 8'h00);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        edge_n = 0;
        cpb[0] = 10;
        cpb[1] = 8;
        model_clear();
        ifa.i_wr_en   = 1'b0;
        ifa.i_wr_data = 8'h00;
        ifb.i_wr_en   = 1'b0;
        ifb.i_wr_data = 8'h00;
        rst_n = 1'b0;

        // Reset state
        idle(3);
        rst_n = 1'b1;

        // Single byte
        step(1'b1, 8'h55);
        idle(110);

        // Back-to-back frames
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        idle(210);

        // Overflow: six consecutive writes into a 4-deep FIFO
        for (int b = 1; b <= 6; b++) step(1'b1, 8'(b));
        idle(520);

        // Data extremes
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        idle(210);

        // Reset in the middle of data bit 3 with two bytes queued
        step(1'b1, 8'($urandom));
        step(1'b1, 8'($urandom));
        step(1'b1, 8'($urandom));
        idle(44);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_tx_a",    32'(ifa.o_tx),         32'd1);
        chk("rst_count_a", 32'(ifa.o_fifo_count), 32'd0);
        chk("rst_busy_a",  32'(ifa.o_busy),       32'd0);
        chk("rst_tx_b",    32'(ifb.o_tx),         32'd1);
        chk("rst_count_b", 32'(ifb.o_fifo_count), 32'd0);
        idle(3);
        rst_n = 1'b1;
        step(1'b1, 8'($urandom));
        idle(110);

        // Random traffic, including occasional overflow
        for (int r = 0; r < 40; r++) begin
            step($urandom_range(0, 3) == 0, 8'($urandom));
        end
        idle(600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
